// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and widths.
package uart_pkg;

  localparam int OSR_DEF = 16;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Host-side and line-side signals of the UART receive stage.
interface uart_rx_if;
  import uart_pkg::*;

  logic              rx_enb;
  logic              Rx;
  logic              rd;
  logic [DATA_W-1:0] data_out;
  logic              rdy;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  modport master (
    output rx_enb, Rx, rd,
    input  data_out, rdy, frame_err, overrun, busy
  );

  modport slave (
    input  rx_enb, Rx, rd,
    output data_out, rdy, frame_err, overrun, busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with selectable reset value.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x-style oversampling and valid/read handshake.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority vote around every sample point.
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | line idle, waiting for rx_s = 0 on a tick
// ST_START | counting to mid start bit to confirm it
// ST_DATA  | sampling 8 data bits, LSB first
// ST_STOP  | sampling stop bit, byte delivered to host
// ST_BREAK | stop bit was 0, waiting for line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int OSR = OSR_DEF
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int            CW      = $clog2(OSR);
  localparam logic [CW-1:0] P_START = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] P_BIT   = CW'(OSR - 1);

  uart_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rdy_q, rdy_d;
  logic              fe_q, fe_d;
  logic              ovr_q, ovr_d;

  logic              rx_s;
  logic              tick;
  logic              sample;
  logic              complete;
  logic [CW-1:0]     p_cur;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.Rx),
    .q_o (rx_s)
  );

  assign tick  = bus.rx_enb;
  assign p_cur = (state_q == ST_START) ? P_START : P_BIT;

`ifdef UART_RX_MAJORITY_EN
  logic maj2_q, maj2_d;
  logic maj1_q, maj1_d;

  // Capture the two ticks preceding the sample point; the third vote is live rx_s.
  always_comb begin
    maj2_d = maj2_q;
    maj1_d = maj1_q;
    if (tick) begin
      if (cnt_q == p_cur - CW'(2)) maj2_d = rx_s;
      if (cnt_q == p_cur - CW'(1)) maj1_d = rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      maj2_q <= 1'b1;
      maj1_q <= 1'b1;
    end else begin
      maj2_q <= maj2_d;
      maj1_q <= maj1_d;
    end
  end

  assign sample = (maj2_q & maj1_q) | (maj2_q & rx_s) | (maj1_q & rx_s);
`else
  assign sample = rx_s;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    complete = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick && !rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (cnt_q == P_START) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = sample ? ST_IDLE : ST_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (cnt_q == P_BIT) begin
            cnt_d          = '0;
            shift_d[idx_q] = sample;
            if (idx_q == 3'd7) state_d = ST_STOP;
            else               idx_d   = idx_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (cnt_q == P_BIT) begin
            cnt_d    = '0;
            complete = 1'b1;
            state_d  = sample ? ST_IDLE : ST_BREAK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_BREAK: begin
        if (tick && rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A completing byte wins over a read; overrun only when the old byte was never taken.
  always_comb begin
    data_d = data_q;
    rdy_d  = rdy_q;
    fe_d   = fe_q;
    ovr_d  = ovr_q;
    if (complete) begin
      data_d = shift_q;
      fe_d   = ~sample;
      rdy_d  = 1'b1;
      ovr_d  = rdy_q & ~bus.rd;
    end else if (bus.rd && rdy_q) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.rdy       = rdy_q;
  assign bus.frame_err = fe_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level model predicts byte delivery and handshake status per cycle.
module tb_uart_rx;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  uart_rx_if u_if ();

  uart_rx #(.OSR(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [7:0] data;
    logic       fe;
  } exp_t;

  exp_t       pend[$];
  logic [7:0] m_data;
  logic       m_rdy;
  logic       m_fe;
  logic       m_ovr;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Frame-level model: a byte lands 2 clk (sync) + 1 (detect tick) + 9.5*OSR ticks after the start bit is driven.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      pend.delete();
      m_data = 8'h00;
      m_rdy  = 1'b0;
      m_fe   = 1'b0;
      m_ovr  = 1'b0;
    end else if (pend.size() > 0 && pend[0].at == cyc) begin
      m_data = pend[0].data;
      m_fe   = pend[0].fe;
      m_ovr  = m_rdy && !u_if.rd;
      m_rdy  = 1'b1;
      void'(pend.pop_front());
    end else if (u_if.rd && m_rdy) begin
      m_rdy = 1'b0;
      m_ovr = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("rdy",       8'(u_if.rdy),       8'(m_rdy));
      chk("data_out",  u_if.data_out,      m_data);
      chk("frame_err", 8'(u_if.frame_err), 8'(m_fe));
      chk("overrun",   8'(u_if.overrun),   8'(m_ovr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd();
    u_if.rd = 1'b1;
    step();
    u_if.rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch);
    int         k;
    logic [7:0] eb;
    exp_t       e;
    k  = cyc;
    eb = b;
`ifndef UART_RX_MAJORITY_EN
    if (glitch >= 0) eb[glitch] = 1'b0;
`endif
    e.at   = k + 155;
    e.data = eb;
    e.fe   = ~stop;
    pend.push_back(e);
    u_if.Rx = 1'b0;
    repeat (16) step();
    for (int i = 0; i < 8; i++) begin
      u_if.Rx = b[i];
      if (i == glitch) begin
        repeat (8) step();
        u_if.Rx = 1'b0;
        step();
        u_if.Rx = b[i];
        repeat (7) step();
      end else begin
        repeat (16) step();
      end
    end
    u_if.Rx = stop;
    repeat (16) step();
  endtask

  initial begin
    logic [7:0] glitch_exp;
    checks      = 0;
    failures    = 0;
    cyc         = 0;
    rst         = 1'b1;
    u_if.Rx     = 1'b1;
    u_if.rd     = 1'b0;
    u_if.rx_enb = 1'b1;
    repeat (3) step();
    chk("reset data_out", u_if.data_out, 8'h00);
    chk("reset rdy",      8'(u_if.rdy),  8'h00);
    chk("reset busy",     8'(u_if.busy), 8'h00);
    rst = 1'b0;
    repeat (5) step();

    send_frame(8'hA5, 1'b1, -1);
    chk("A5 data", u_if.data_out,      8'hA5);
    chk("A5 rdy",  8'(u_if.rdy),       8'h01);
    chk("A5 fe",   8'(u_if.frame_err), 8'h00);
    chk("A5 busy", 8'(u_if.busy),      8'h00);
    pulse_rd();
    chk("A5 rd clears rdy", 8'(u_if.rdy), 8'h00);

    u_if.Rx = 1'b0;
    repeat (4) step();
    u_if.Rx = 1'b1;
    repeat (2) step();
    chk("false start busy high", 8'(u_if.busy), 8'h01);
    repeat (10) step();
    chk("false start busy low", 8'(u_if.busy), 8'h00);
    chk("false start rdy",      8'(u_if.rdy),  8'h00);

    send_frame(8'h3C, 1'b0, -1);
    repeat (40) step();
    chk("break busy", 8'(u_if.busy),      8'h01);
    chk("break data", u_if.data_out,      8'h3C);
    chk("break fe",   8'(u_if.frame_err), 8'h01);
    u_if.Rx = 1'b1;
    repeat (5) step();
    chk("break exit busy", 8'(u_if.busy), 8'h00);
    pulse_rd();

    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    chk("overrun data", u_if.data_out,    8'h22);
    chk("overrun flag", 8'(u_if.overrun), 8'h01);
    pulse_rd();
    chk("overrun cleared", 8'(u_if.overrun), 8'h00);
    chk("rdy cleared",     8'(u_if.rdy),     8'h00);

    send_frame(8'h11, 1'b1, -1);
    fork
      send_frame(8'h22, 1'b1, -1);
      begin
        repeat (154) step();
        pulse_rd();
      end
    join
    chk("coincident rd rdy",     8'(u_if.rdy),     8'h01);
    chk("coincident rd overrun", 8'(u_if.overrun), 8'h00);
    chk("coincident rd data",    u_if.data_out,    8'h22);
    pulse_rd();

`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'hFF;
`else
    glitch_exp = 8'hF7;
`endif
    send_frame(8'hFF, 1'b1, 3);
    chk("glitch data", u_if.data_out, glitch_exp);
    pulse_rd();

    u_if.Rx = 1'b0;
    repeat (16) step();
    for (int i = 0; i < 3; i++) begin
      u_if.Rx = (i == 1) ? 1'b1 : 1'b0;
      repeat (16) step();
    end
    chk("mid-frame busy", 8'(u_if.busy), 8'h01);
    rst = 1'b1;
    repeat (2) step();
    chk("mid reset data", u_if.data_out,      8'h00);
    chk("mid reset busy", 8'(u_if.busy),      8'h00);
    chk("mid reset fe",   8'(u_if.frame_err), 8'h00);
    rst     = 1'b0;
    u_if.Rx = 1'b1;
    repeat (20) step();
    chk("post reset rdy", 8'(u_if.rdy), 8'h00);

    send_frame(8'h81, 1'b1, -1);
    chk("81 data", u_if.data_out, 8'h81);
    chk("81 rdy",  8'(u_if.rdy),  8'h01);
    pulse_rd();
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receive stage. It consumes the 8N1 line driven by the team's UART transmitter and oversamples it with a 16x baud tick. It validates the start bit, shifts in 8 data bits LSB first, and checks the stop bit. Each received byte is presented on a valid/read handshake to the host-side consumer, with framing-error and overrun status.

## Interface
- OSR, 16, oversample ticks per bit; power of two, ≥ 8.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- rx_enb  in  1  oversample tick, one-cycle pulse at OSR × baud. Shares its source with the transmitter's baud tick through a fixed divider.
- Rx  in  1  asynchronous serial line; idles high.
- rd  in  1  one-cycle pulse; consumer has taken data_out.
- data_out  out  8  last received byte.
- rdy  out  1  data_out valid, held until rd.
- frame_err  out  1  stop bit of the byte in data_out was 0.
- overrun  out  1  a byte completed while rdy was already 1 (sticky).
- busy  out  1  state ≠ IDLE.

## Operation
- Rx passes through a 2-flop synchronizer (reset value 1) to give rx_s. All decisions use rx_s.
- cnt is a log2(OSR)-bit counter that advances only on rx_enb. idx is a 3-bit bit index. shift is an 8-bit shift register.
- IDLE: on an rx_enb tick with rx_s = 0, go to START with cnt ← 0.
- START: on each tick, cnt++. When cnt = OSR/2−1, sample.
  - Sample = 1: false start; go to IDLE.
  - Sample = 0: go to DATA with cnt ← 0 and idx ← 0.
- DATA: on each tick, cnt++. When cnt = OSR−1, sample into shift[idx].
  - idx = 7: go to STOP with cnt ← 0.
  - Otherwise: idx++.
- STOP: when cnt = OSR−1, sample the stop bit.
  - On sampling: data_out ← shift, rdy ← 1, frame_err ← (stop = 0).
  - Stop = 1: go to IDLE.
  - Stop = 0: go to BREAK.
- BREAK: stay until an rx_enb tick sees rx_s = 1, then go to IDLE. This prevents a held-low line from retriggering.
- Handshake:
  - rd with rdy = 1 clears rdy and overrun on the next edge.
  - rd with rdy = 0 is ignored.
  - On completion while rdy = 1 and no rd in the same cycle: data_out is overwritten and overrun ← 1.
  - On completion in the same cycle as rd: the new byte is loaded, rdy stays 1, overrun ← 0.
- Ticks with rx_enb = 0 change nothing except the synchronizer and handshake.

## Timing
- Reset values: data_out = 0x00, rdy = 0, frame_err = 0, overrun = 0, busy = 0, state = IDLE, cnt = 0, idx = 0. Reset mid-frame abandons the frame with no rdy.
- Rx → rx_s latency is 2 clk.
- rdy, data_out, and frame_err update on the clk edge of the rx_enb tick that samples the stop bit. They are registered, so they are visible the following cycle.
- For a valid frame, rdy rises (9.5 × OSR) ± 1 ticks after the tick that first sees rx_s = 0.
- busy rises one clk after the start detection tick. It falls when IDLE is re-entered.

## Configuration
- UART_RX_MAJORITY_EN
  - Defined: every sample point (START, DATA, STOP) uses the 2-of-3 majority of rx_s captured at cnt = P−2, P−1, and P, where P is the nominal sample count. A single-tick glitch at the sample point is rejected.
  - Undefined: a single sample of rx_s is taken at cnt = P, and the majority registers are not built.
  - Frame timing is identical in both builds.

## Structure
- uart_pkg: state encoding (IDLE, START, DATA, STOP, BREAK; 3-bit), OSR default, data width constant 8. This package is shared with the transmitter.
- Sub-module uart_rx_sync: a 2-flop synchronizer with a reset value parameter (1 here).
- The FSM, counters, and handshake are written inline.

## Test plan
- Frame 0xA5, rx_enb every cycle, OSR = 16 → data_out = 0xA5, rdy = 1, frame_err = 0. rd pulse → rdy = 0 next cycle.
- Rx low for 4 ticks, then high → state returns to IDLE at START check, rdy stays 0, busy pulses.
- Frame 0x3C with stop bit 0, then line held low 40 ticks → data_out = 0x3C, frame_err = 1, state BREAK until Rx goes high, and no second byte.
- Frames 0x11 then 0x22 without rd → data_out = 0x22, overrun = 1. rd clears both rdy and overrun. A repeat with rd coincident with the second completion → rdy = 1, overrun = 0.
- Frame 0xFF with a one-tick low glitch at the bit-3 sample point → 0xF7 with the macro undefined; 0xFF with UART_RX_MAJORITY_EN defined.
- rst asserted mid-DATA of 0x5A → all outputs return to reset values. The next clean frame 0x81 is received correctly.
